ext_stage: RTL

- Parametrised extension and alignment stage for the multicycle MIPS datapath.
- Generalises immediate extension (zero, sign, high-position) and adds load-data lane selection with byte/half sign/zero extension.
- The result is registered behind a valid/ready handshake, so the stage stands between memory/IR and the ALU/MDR path.
- Detects misaligned half/word loads and counts them.

---
 rtl/ext_pkg.sv | 37 +++
 rtl/ext_lane_sel.sv | 80 ++++++++
 rtl/ext_stage.sv | 98 +++++++++
 3 files changed

// File: rtl/ext_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ext_pkg
// Description : Shared definitions for the extension/alignment stage.
//               Holds the 3-bit extension mode encodings and the load
//               misalignment predicate.
// Revision    : 1.0 - initial release
// ============================================================================
package ext_pkg;

    // Extension mode encodings (3-bit).
    typedef enum logic [2:0] {
        EXT_ZERO    = 3'd0,
        EXT_SIGNED  = 3'd1,
        EXT_HIGHPOS = 3'd2,
        EXT_LB      = 3'd3,
        EXT_LBU     = 3'd4,
        EXT_LH      = 3'd5,
        EXT_LHU     = 3'd6,
        EXT_LW      = 3'd7
    } ext_mode_e;

    // Half loads need an even byte offset and word loads need offset 0.
    // Byte loads and immediate modes never fault.
    function automatic logic ext_misaligned(input ext_mode_e mode,
                                            input logic [1:0] addr_lo);
        logic mis;
        case (mode)
            EXT_LH, EXT_LHU: mis = addr_lo[0];
            EXT_LW:          mis = (addr_lo != 2'b00);
            default:         mis = 1'b0;
        endcase
        return mis;
    endfunction

endpackage : ext_pkg
`default_nettype wire

// File: rtl/ext_lane_sel.sv
`default_nettype none
// ============================================================================
// Module      : ext_lane_sel
// Description : Combinational immediate extension and load lane selection.
//               Produces the extended value and a misalignment flag; the
//               value is forced to zero for a misaligned load.
//               Build option: EXT_BIG_ENDIAN_EN selects big-endian lanes.
// Revision    : 1.0 - initial release
// ============================================================================
module ext_lane_sel
    import ext_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int IMM_W  = 16
) (
    input  logic [DATA_W-1:0] din,
    input  logic [1:0]        addr_lo,
    input  logic [2:0]        mode,
    output logic [DATA_W-1:0] ext_val,
    output logic              misalign
);

    ext_mode_e         mode_e;
    logic [31:0]       word;
    logic [IMM_W-1:0]  imm;
    logic [1:0]        byte_lane;
    logic              half_lane;
    logic [7:0]        lane_byte;
    logic [15:0]       lane_half;
    logic [DATA_W-1:0] word_ext;

    assign mode_e = ext_mode_e'(mode);
    assign word   = din[31:0];
    assign imm    = din[IMM_W-1:0];

`ifdef EXT_BIG_ENDIAN_EN
    // Big-endian: byte offset 0 is the most significant lane.
    assign byte_lane = 2'd3 - addr_lo;
    assign half_lane = ~addr_lo[1];
`else
    // Little-endian: byte offset 0 is the least significant lane.
    assign byte_lane = addr_lo;
    assign half_lane = addr_lo[1];
`endif

    assign lane_byte = word[{byte_lane, 3'b000} +: 8];
    assign lane_half = half_lane ? word[31:16] : word[15:0];

    // Word loads are sign-extended only when the datapath is wider than 32.
    generate
        if (DATA_W > 32) begin : g_word_sext
            logic unused_din_hi;
            assign unused_din_hi = ^din[DATA_W-1:32];
            assign word_ext      = {{(DATA_W-32){word[31]}}, word};
        end else begin : g_word_native
            assign word_ext = word;
        end
    endgenerate

    // Select the extended result; a faulting load yields zero.
    always_comb begin
        misalign = ext_misaligned(mode_e, addr_lo);
        ext_val  = '0;
        if (!misalign) begin
            case (mode_e)
                EXT_ZERO:    ext_val = {{(DATA_W-IMM_W){1'b0}}, imm};
                EXT_SIGNED:  ext_val = {{(DATA_W-IMM_W){imm[IMM_W-1]}}, imm};
                EXT_HIGHPOS: ext_val = {imm, {(DATA_W-IMM_W){1'b0}}};
                EXT_LB:      ext_val = {{(DATA_W-8){lane_byte[7]}}, lane_byte};
                EXT_LBU:     ext_val = {{(DATA_W-8){1'b0}}, lane_byte};
                EXT_LH:      ext_val = {{(DATA_W-16){lane_half[15]}}, lane_half};
                EXT_LHU:     ext_val = {{(DATA_W-16){1'b0}}, lane_half};
                EXT_LW:      ext_val = word_ext;
                default:     ext_val = '0;
            endcase
        end
    end

endmodule : ext_lane_sel
`default_nettype wire

// File: rtl/ext_stage.sv
`default_nettype none
// ============================================================================
// Module      : ext_stage
// Description : Registered extension/alignment stage with valid/ready
//               handshake, flush, misalignment flag and saturating
//               misalignment counter.
//               Build option: EXT_BIG_ENDIAN_EN (big-endian load lanes).
//               DATA_W must be 32 or 64; IMM_W <= DATA_W/2.
// Revision    : 1.0 - initial release
// ============================================================================
module ext_stage
    import ext_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int IMM_W     = 16,
    parameter int ERR_CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 flush,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [2:0]           mode,
    input  logic [1:0]           addr_lo,
    input  logic [DATA_W-1:0]    din,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [DATA_W-1:0]    dout,
    output logic                 err_misalign,
    output logic [ERR_CNT_W-1:0] err_cnt
);

    logic [DATA_W-1:0]    ext_val;
    logic                 ext_mis;
    logic                 accept;

    logic                 valid_d,   valid_q;
    logic [DATA_W-1:0]    dout_d,    dout_q;
    logic                 err_d,     err_q;
    logic [ERR_CNT_W-1:0] err_cnt_d, err_cnt_q;

    ext_lane_sel #(
        .DATA_W (DATA_W),
        .IMM_W  (IMM_W)
    ) u_lane_sel (
        .din      (din),
        .addr_lo  (addr_lo),
        .mode     (mode),
        .ext_val  (ext_val),
        .misalign (ext_mis)
    );

    assign in_ready = !valid_q || out_ready;
    assign accept   = in_valid && in_ready;

    // Next-state for the output register; flush overrides any accept.
    always_comb begin
        valid_d   = valid_q;
        dout_d    = dout_q;
        err_d     = err_q;
        err_cnt_d = err_cnt_q;
        if (flush) begin
            valid_d = 1'b0;
            err_d   = 1'b0;
        end else if (accept) begin
            valid_d = 1'b1;
            dout_d  = ext_val;
            err_d   = ext_mis;
            if (ext_mis && !(&err_cnt_q)) begin
                err_cnt_d = err_cnt_q + 1'b1;
            end
        end else if (out_ready) begin
            valid_d = 1'b0;
        end
    end

    // Output register with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q   <= 1'b0;
            dout_q    <= '0;
            err_q     <= 1'b0;
            err_cnt_q <= '0;
        end else begin
            valid_q   <= valid_d;
            dout_q    <= dout_d;
            err_q     <= err_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    assign out_valid    = valid_q;
    assign dout         = dout_q;
    assign err_misalign = err_q;
    assign err_cnt      = err_cnt_q;

endmodule : ext_stage
`default_nettype wire
